// File: rtl/piano_pkg.sv
// Shared types and constants for the note sequencer: FSM state encoding,
// note-code constants, ROM field widths and the pitch half-period table.
package piano_pkg;

  localparam int unsigned CODE_W     = 5;
  localparam int unsigned DUR_W      = 4;
  localparam int unsigned FREQ_W     = 18;
  localparam int unsigned ROM_W      = CODE_W + DUR_W;
  localparam int unsigned NOTE_COUNT = 21;

  localparam logic [CODE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [CODE_W-1:0] NOTE_C4   = 5'd1;
  localparam logic [CODE_W-1:0] NOTE_A4   = 5'd6;
  localparam logic [CODE_W-1:0] NOTE_C5   = 5'd8;
  localparam logic [CODE_W-1:0] NOTE_C6   = 5'd15;
  localparam logic [CODE_W-1:0] NOTE_B6   = 5'd21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  typedef logic [FREQ_W-1:0] hp_table_t [NOTE_COUNT];

  // Natural notes C4..B6 in milli-hertz (equal temperament, A4 = 440 Hz).
  localparam longint unsigned NOTE_MHZ [NOTE_COUNT] = '{
    64'd261626,  64'd293665,  64'd329628,  64'd349228,
    64'd391995,  64'd440000,  64'd493883,
    64'd523251,  64'd587330,  64'd659255,  64'd698456,
    64'd783991,  64'd880000,  64'd987767,
    64'd1046502, 64'd1174659, 64'd1318510, 64'd1396913,
    64'd1567982, 64'd1760000, 64'd1975533
  };

  function automatic logic is_pitched(input logic [CODE_W-1:0] code);
    return (code >= NOTE_C4) && (code <= NOTE_B6);
  endfunction

  // Half-period counts round(clk/(2f)) - 1, evaluated at elaboration time.
  function automatic hp_table_t build_half_periods(input longint unsigned clk_hz);
    hp_table_t t;
    for (int unsigned i = 0; i < NOTE_COUNT; i++) begin
      t[i] = FREQ_W'(((clk_hz * 64'd1000) + NOTE_MHZ[i]) / (64'd2 * NOTE_MHZ[i]) - 64'd1);
    end
    return t;
  endfunction

endpackage

// File: rtl/note_freq_lut.sv
// Combinational note code -> buzzer half-period count; rests map to 0.
module note_freq_lut
  import piano_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic [CODE_W-1:0] code,
  output logic [FREQ_W-1:0] freq
);

  localparam hp_table_t HALF_PERIOD = build_half_periods(64'(CLK_HZ));

  // Table lookup for the 21 pitched codes, zero otherwise.
  always_comb begin
    freq = '0;
    if (is_pitched(code)) begin
      freq = HALF_PERIOD[code - NOTE_C4];
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Song ROM sequencer: fetches {note, duration} words, plays each note for
// duration ticks followed by a silent articulation gap.
// Build option: define SONG_LOOP_EN to restart from address 0 at the end
// marker instead of returning to idle.
module note_sequencer
  import piano_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TICK_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic [FREQ_W-1:0] freq,
  output logic              sound_en,
  output logic [CODE_W-1:0] note_code,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  state_t              state;
  logic [TW-1:0]       tick_cnt;
  logic [DUR_W-1:0]    ticks_left;
  logic [GW-1:0]       gap_cnt;
  logic [FREQ_W-1:0]   freq_r;
  logic                sound_r;
  logic [CODE_W-1:0]   note_r;
  logic [FREQ_W-1:0]   lut_freq;
  logic [CODE_W-1:0]   rom_code;
  logic [DUR_W-1:0]    rom_dur;
  logic                playing;

  assign rom_code = rom_data[ROM_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  note_freq_lut #(.CLK_HZ(CLK_HZ)) u_lut (
    .code (rom_code),
    .freq (lut_freq)
  );

  // Pause silences the registered pitch without disturbing it, so release
  // resumes the same note with the remaining count intact.
  assign playing   = (state == S_PLAY) && !pause;
  assign freq      = playing ? freq_r : '0;
  assign sound_en  = playing && sound_r;
  assign note_code = note_r;
  assign busy      = (state != S_IDLE);

  // Sequencer FSM with tick/gap timing and registered note outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rom_addr   <= '0;
      tick_cnt   <= '0;
      ticks_left <= '0;
      gap_cnt    <= '0;
      freq_r     <= '0;
      sound_r    <= 1'b0;
      note_r     <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= S_IDLE;
        tick_cnt   <= '0;
        ticks_left <= '0;
        gap_cnt    <= '0;
        freq_r     <= '0;
        sound_r    <= 1'b0;
        note_r     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              rom_addr <= '0;
              state    <= S_FETCH;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            if (rom_dur == '0) begin
              done <= 1'b1;
`ifdef SONG_LOOP_EN
              rom_addr <= '0;
              state    <= S_FETCH;
`else
              state    <= S_IDLE;
`endif
            end else begin
              freq_r     <= lut_freq;
              sound_r    <= is_pitched(rom_code);
              note_r     <= is_pitched(rom_code) ? rom_code : NOTE_REST;
              ticks_left <= rom_dur;
              tick_cnt   <= '0;
              state      <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (!pause) begin
              if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                if (ticks_left == DUR_W'(1)) begin
                  ticks_left <= '0;
                  freq_r     <= '0;
                  sound_r    <= 1'b0;
                  note_r     <= '0;
                  if (GAP_CYCLES == 0) begin
                    rom_addr <= rom_addr + ADDR_W'(1);
                    state    <= S_FETCH;
                  end else begin
                    gap_cnt <= '0;
                    state   <= S_GAP;
                  end
                end else begin
                  ticks_left <= ticks_left - DUR_W'(1);
                end
              end else begin
                tick_cnt <= tick_cnt + TW'(1);
              end
            end
          end
          S_GAP: begin
            if (!pause) begin
              if (gap_cnt == GAP_LAST) begin
                gap_cnt  <= '0;
                rom_addr <= rom_addr + ADDR_W'(1);
                state    <= S_FETCH;
              end else begin
                gap_cnt <= gap_cnt + GW'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_CYCLES=4, GAP_CYCLES=2.
module tb_note_sequencer;

  localparam int unsigned ADDR_W = 8;
  localparam logic [17:0] F_A4 = 18'd113635;
  localparam logic [17:0] F_C4 = 18'd191112;
  localparam logic [17:0] F_B6 = 18'd25309;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [8:0]        rom_data = '0;
  logic [17:0]       freq;
  logic              sound_en;
  logic [4:0]        note_code;
  logic              busy;
  logic              done;

  logic [8:0] rom_mem [256];
  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int sounding;

  note_sequencer #(
    .CLK_HZ      (100_000_000),
    .TICK_CYCLES (4),
    .GAP_CYCLES  (2),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .freq      (freq),
    .sound_en  (sound_en),
    .note_code (note_code),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    logic        start;
    logic        stop;
    logic        pause;
    logic [17:0] f;
    logic        s;
    logic [4:0]  n;
    logic        b;
    logic        d;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic load_rom(input logic [8:0] w0, input logic [8:0] w1, input logic [8:0] w2);
    for (int i = 0; i < 256; i++) rom_mem[i] = 9'd0;
    rom_mem[0] = w0;
    rom_mem[1] = w1;
    rom_mem[2] = w2;
  endtask

  task automatic go();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic adv(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic to_idle();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("stop_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 9'd0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_freq", 32'(freq), 32'd0);
    chk("rst_sound", 32'(sound_en), 32'd0);
    chk("rst_note", 32'(note_code), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: A4 dur2 then end marker; start while busy at vector 5 is ignored,
    // pause while fetching has no effect.
    load_rom({5'd6, 4'd2}, 9'd0, 9'd0);
    for (int i = 0; i < 16; i++) vt[i] = '{1'b0, 1'b0, 1'b0, 18'd0, 1'b0, 5'd0, 1'b1, 1'b0};
    vt[0].start = 1'b1;
    vt[1].pause = 1'b1;
    vt[5].start = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      vt[i].f = F_A4;
      vt[i].s = 1'b1;
      vt[i].n = 5'd6;
    end
    vt[14].d = 1'b1;
`ifndef SONG_LOOP_EN
    vt[14].b = 1'b0;
    vt[15].b = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      start = vt[i].start;
      stop  = vt[i].stop;
      pause = vt[i].pause;
      @(posedge clk); #1;
      cyc = i + 1;
      chk("tbl_freq", 32'(freq), 32'(vt[i].f));
      chk("tbl_sound", 32'(sound_en), 32'(vt[i].s));
      chk("tbl_note", 32'(note_code), 32'(vt[i].n));
      chk("tbl_busy", 32'(busy), 32'(vt[i].b));
      chk("tbl_done", 32'(done), 32'(vt[i].d));
    end
    start = 1'b0;
    pause = 1'b0;
    to_idle();

    // Rest dur1, C4 dur1, end.
    load_rom({5'd0, 4'd1}, {5'd1, 4'd1}, 9'd0);
    go();
    for (int k = 2; k <= 20; k++) begin
      adv(k);
      chk("rest_freq", 32'(freq), (k >= 11 && k <= 14) ? 32'(F_C4) : 32'd0);
      chk("rest_sound", 32'(sound_en), (k >= 11 && k <= 14) ? 32'd1 : 32'd0);
      chk("rest_note", 32'(note_code), (k >= 11 && k <= 14) ? 32'd1 : 32'd0);
      chk("rest_done", 32'(done), (k == 19) ? 32'd1 : 32'd0);
`ifndef SONG_LOOP_EN
      chk("rest_busy", 32'(busy), (k < 19) ? 32'd1 : 32'd0);
`endif
    end
    to_idle();

    // Pause for three cycles in the middle of an A4 dur2 note.
    load_rom({5'd6, 4'd2}, 9'd0, 9'd0);
    go();
    sounding = 0;
    for (int k = 2; k <= 20; k++) begin
      adv(k);
      pause = (k >= 5 && k <= 7);
      #1;
      if (sound_en) sounding++;
      if (k >= 5 && k <= 7) chk("pause_silent", 32'(freq), 32'd0);
      if (k == 13) chk("pause_last_play", 32'(freq), 32'(F_A4));
      if (k == 14) chk("pause_gap", 32'(freq), 32'd0);
      if (k == 18) chk("pause_done", 32'(done), 32'd1);
    end
    pause = 1'b0;
    chk("pause_total", 32'(sounding), 32'd8);
    to_idle();

    // stop together with start during PLAY.
    go();
    adv(4);
    chk("stop_pre", 32'(freq), 32'(F_A4));
    stop = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    start = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_freq", 32'(freq), 32'd0);
    chk("stop_sound", 32'(sound_en), 32'd0);
    @(posedge clk); #1;
    chk("stop_stays", 32'(busy), 32'd0);

    // Reset during the gap after the second note.
    load_rom({5'd0, 4'd1}, {5'd1, 4'd1}, 9'd0);
    go();
    adv(15);
    chk("gap_addr", 32'(rom_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_addr", 32'(rom_addr), 32'd0);
    chk("arst_freq", 32'(freq), 32'd0);
    chk("arst_note", 32'(note_code), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    go();
    chk("rerun_addr", 32'(rom_addr), 32'd0);
    adv(11);
    chk("rerun_freq", 32'(freq), 32'(F_C4));
    to_idle();

    // B6 dur1 then end marker.
    load_rom({5'd21, 4'd1}, 9'd0, 9'd0);
    go();
    adv(3);
    chk("b6_freq", 32'(freq), 32'(F_B6));
    chk("b6_note", 32'(note_code), 32'd21);
    adv(9);
    chk("b6_addr1", 32'(rom_addr), 32'd1);
    adv(11);
    chk("b6_done", 32'(done), 32'd1);
`ifdef SONG_LOOP_EN
    chk("loop_addr", 32'(rom_addr), 32'd0);
    chk("loop_busy", 32'(busy), 32'd1);
    adv(13);
    chk("loop_freq", 32'(freq), 32'(F_B6));
    adv(19);
    chk("loop_addr1", 32'(rom_addr), 32'd1);
    adv(21);
    chk("loop_done2", 32'(done), 32'd1);
    to_idle();
`else
    chk("end_busy", 32'(busy), 32'd0);
    adv(12);
    chk("end_done_clr", 32'(done), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
